// File: rtl/fcn_pkg.sv
// fcn_pkg: shared types, default widths and small helpers for the
// FC-core class sequencer (fcn_class_seq) and its argmax register.
package fcn_pkg;

    localparam int LOGIT_W_DEF = 24;
    localparam int GRP_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FINISH  = 3'd4
    } fcn_seq_state_e;

    // Class index width: ceil(log2(n)), never below one bit.
    function automatic int cls_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed strict greater-than; callers sign-extend their operands to 64 bits.
    function automatic logic signed_gt(input logic signed [63:0] a,
                                       input logic signed [63:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/fcn_class_seq_if.sv
// fcn_class_seq_if: link between the class sequencer (master) and the
// fully-connected core plus its weight memories (slave).
interface fcn_class_seq_if
    import fcn_pkg::*;
#(
    parameter int LOGIT_W = LOGIT_W_DEF,
    parameter int CLS_W   = 4,
    parameter int GRP_W   = GRP_W_DEF
);
    logic                      fcn_start;
    logic                      fcn_done;
    logic signed [LOGIT_W-1:0] fcn_logit;
    logic                      fcn_fc1_valid;
    logic                      fcn_fc1_next;
    logic [CLS_W-1:0]          cls_sel_o;
    logic [GRP_W-1:0]          fc1_group_o;

    modport master (
        output fcn_start,
        output fcn_fc1_next,
        output cls_sel_o,
        output fc1_group_o,
        input  fcn_done,
        input  fcn_logit,
        input  fcn_fc1_valid
    );

    modport slave (
        input  fcn_start,
        input  fcn_fc1_next,
        input  cls_sel_o,
        input  fc1_group_o,
        output fcn_done,
        output fcn_logit,
        output fcn_fc1_valid
    );

endinterface

// File: rtl/fcn_argmax_reg.sv
// fcn_argmax_reg: running signed maximum with its class index.
// clear_i arms the "first" flag so the next valid logit always wins,
// which keeps an all-negative logit set from reporting a stale zero.
module fcn_argmax_reg
    import fcn_pkg::*;
#(
    parameter int LOGIT_W = LOGIT_W_DEF,
    parameter int CLS_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      valid_i,
    input  logic signed [LOGIT_W-1:0] logit_i,
    input  logic [CLS_W-1:0]          idx_i,
    output logic signed [LOGIT_W-1:0] max_o,
    output logic [CLS_W-1:0]          idx_o
);

    logic                      first_q, first_d;
    logic signed [LOGIT_W-1:0] max_q,   max_d;
    logic [CLS_W-1:0]          idx_q,   idx_d;

    // Next-state: strictly greater replaces, so ties keep the lower index.
    always_comb begin
        first_d = first_q;
        max_d   = max_q;
        idx_d   = idx_q;
        if (clear_i) begin
            first_d = 1'b1;
        end else if (valid_i) begin
            if (first_q || signed_gt(64'(logit_i), 64'(max_q))) begin
                max_d = logit_i;
                idx_d = idx_i;
            end
            first_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            first_q <= first_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    assign max_o = max_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/fcn_class_seq.sv
// fcn_class_seq: runs the FC core once per output class, selects the FC2
// weight row, auto-acknowledges FC1 group completions and reports the
// argmax class with its logit.
// Optional build macro FCN_LOGIT_DUMP_EN adds the logits_o per-class dump.
module fcn_class_seq
    import fcn_pkg::*;
#(
    parameter int  NUM_CLASS = 10,
    parameter int  LOGIT_W   = LOGIT_W_DEF,
    parameter int  GRP_W     = GRP_W_DEF,
    localparam int CLS_W     = cls_w_f(NUM_CLASS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CLS_W-1:0]          class_o,
    output logic signed [LOGIT_W-1:0] max_logit_o,
`ifdef FCN_LOGIT_DUMP_EN
    output logic signed [LOGIT_W-1:0] logits_o [NUM_CLASS],
`endif
    fcn_class_seq_if.master           core
);

    fcn_seq_state_e            state_q, state_d;
    logic [CLS_W-1:0]          cls_q,   cls_d;
    logic [GRP_W-1:0]          grp_q,   grp_d;
    logic                      start_q, start_d;
    logic                      next_q,  next_d;
    logic                      busy_q,  busy_d;
    logic                      done_q,  done_d;
    logic [CLS_W-1:0]          class_q, class_d;
    logic signed [LOGIT_W-1:0] max_q,   max_d;

    logic                      accept;
    logic                      capture;
    logic signed [LOGIT_W-1:0] am_max;
    logic [CLS_W-1:0]          am_idx;

    fcn_argmax_reg #(
        .LOGIT_W (LOGIT_W),
        .CLS_W   (CLS_W)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clear_i (accept),
        .valid_i (capture),
        .logit_i (core.fcn_logit),
        .idx_i   (cls_q),
        .max_o   (am_max),
        .idx_o   (am_idx)
    );

    // Next-state and output decode; fcn_fc1_next and done_o are single-cycle pulses.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        grp_d   = grp_q;
        start_d = start_q;
        next_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        class_d = class_q;
        max_d   = max_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    cls_d   = '0;
                    grp_d   = '0;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A group pulse coinciding with done is still acknowledged;
                // the ack then lands in the first CAPTURE cycle.
                if (core.fcn_fc1_valid) begin
                    next_d = 1'b1;
                    grp_d  = grp_q + GRP_W'(1);
                end
                if (core.fcn_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                start_d = 1'b0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // The core holds done until it has seen start drop; relaunch
                // only once done is low so RUN does not see a stale done.
                if (!core.fcn_done) begin
                    if (cls_q == CLS_W'(NUM_CLASS - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        cls_d   = cls_q + CLS_W'(1);
                        grp_d   = '0;
                        start_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FINISH: begin
                class_d = am_idx;
                max_d   = am_max;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state, counters and outputs; reset returns everything to zero / IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            grp_q   <= '0;
            start_q <= 1'b0;
            next_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            class_q <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            grp_q   <= grp_d;
            start_q <= start_d;
            next_q  <= next_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            class_q <= class_d;
            max_q   <= max_d;
        end
    end

`ifdef FCN_LOGIT_DUMP_EN
    logic signed [LOGIT_W-1:0] logits_q [NUM_CLASS];

    // Per-class logit capture; wiped on reset and whenever a new classification starts.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                logits_q[i] <= '0;
            end
        end else if (capture) begin
            logits_q[cls_q] <= core.fcn_logit;
        end
    end

    assign logits_o = logits_q;
`endif

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign class_o           = class_q;
    assign max_logit_o       = max_q;
    assign core.fcn_start    = start_q;
    assign core.fcn_fc1_next = next_q;
    assign core.cls_sel_o    = cls_q;
    assign core.fc1_group_o  = grp_q;

endmodule

// File: tb/tb_fcn_class_seq.sv
// tb_fcn_class_seq: randomized bench for fcn_class_seq with a behavioural
// FC-core model and an argmax reference kept in the bench.
module tb_fcn_class_seq;
    import fcn_pkg::*;

    localparam int NC  = 4;
    localparam int LW  = 24;
    localparam int GW  = 8;
    localparam int CW  = 2;
    localparam int CW1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    logic                 busy4, done4;
    logic [CW-1:0]        class4;
    logic signed [LW-1:0] max4;
    logic                 busy1, done1;
    logic [CW1-1:0]       class1;
    logic signed [LW-1:0] max1;
`ifdef FCN_LOGIT_DUMP_EN
    logic signed [LW-1:0] dump4 [NC];
    logic signed [LW-1:0] dump1 [1];
`endif

    fcn_class_seq_if #(.LOGIT_W(LW), .CLS_W(CW),  .GRP_W(GW)) cif4 ();
    fcn_class_seq_if #(.LOGIT_W(LW), .CLS_W(CW1), .GRP_W(GW)) cif1 ();

    fcn_class_seq #(.NUM_CLASS(NC), .LOGIT_W(LW), .GRP_W(GW)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start4),
        .busy_o      (busy4),
        .done_o      (done4),
        .class_o     (class4),
        .max_logit_o (max4),
`ifdef FCN_LOGIT_DUMP_EN
        .logits_o    (dump4),
`endif
        .core        (cif4)
    );

    fcn_class_seq #(.NUM_CLASS(1), .LOGIT_W(LW), .GRP_W(GW)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start1),
        .busy_o      (busy1),
        .done_o      (done1),
        .class_o     (class1),
        .max_logit_o (max1),
`ifdef FCN_LOGIT_DUMP_EN
        .logits_o    (dump1),
`endif
        .core        (cif1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logit returned by the core for each class (row selected by cls_sel_o).
    logic signed [LW-1:0] tab [NC];
    int pulses_cfg = -1;   // <0: random 0..3 FC1 pulses per run

    // Reference argmax: first index wins ties, fully signed.
    task automatic ref_argmax(output int idx, output longint mx);
        idx = 0;
        mx  = tab[0];
        for (int i = 1; i < NC; i++) begin
            if (longint'(tab[i]) > mx) begin
                idx = i;
                mx  = tab[i];
            end
        end
    endtask

    // Behavioural FC core for dut4: samples at negedge, updates just after posedge.
    initial begin : core4
        int  c_st, c_cnt, c_pl;
        logic s_start, s_rst;
        logic [CW-1:0] s_cls;
        c_st = 0; c_cnt = 0; c_pl = 0;
        cif4.fcn_done      = 1'b0;
        cif4.fcn_logit     = '0;
        cif4.fcn_fc1_valid = 1'b0;
        forever begin
            @(negedge clk);
            s_start = cif4.fcn_start;
            s_cls   = cif4.cls_sel_o;
            s_rst   = rst;
            @(posedge clk);
            #1;
            cif4.fcn_fc1_valid = 1'b0;
            if (s_rst) begin
                c_st = 0;
                cif4.fcn_done = 1'b0;
            end else begin
                case (c_st)
                    0: if (s_start) begin
                        c_cnt = $urandom_range(1, 5);
                        c_pl  = (pulses_cfg < 0) ? $urandom_range(0, 3) : pulses_cfg;
                        c_st  = 1;
                    end
                    1: begin
                        if (c_pl > 0 && $urandom_range(0, 1) == 1) begin
                            cif4.fcn_fc1_valid = 1'b1;
                            c_pl--;
                        end
                        if (c_cnt > 0) c_cnt--;
                        else if (c_pl == 0) begin
                            cif4.fcn_done  = 1'b1;
                            cif4.fcn_logit = tab[s_cls];
                            c_st = 2;
                        end
                    end
                    2: if (!s_start) c_st = 3;
                    default: begin
                        cif4.fcn_done = 1'b0;
                        c_st = 0;
                    end
                endcase
            end
        end
    end

    // Monitor state for dut4.
    int     mon_launch = 0;
    int     mon_done   = 0;
    logic   prev_valid = 1'b0;
    logic   prev_rst   = 1'b1;
    logic   prev_start = 1'b0;
    bit     m_busy     = 0;
    int     m_run      = 0;
    int     exp_grp    = 0;
    int     exp_cls_o  = 0;
    longint exp_max_o  = 0;

    // Per-cycle compare of dut4 against the model.
    initial begin : monitor4
        int     ridx;
        longint rmax;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_busy",  busy4, 0);
                chk("rst_start", cif4.fcn_start, 0);
                chk("rst_next",  cif4.fcn_fc1_next, 0);
                chk("rst_done",  done4, 0);
                chk("rst_class", class4, 0);
                chk("rst_max",   max4, 0);
                chk("rst_grp",   cif4.fc1_group_o, 0);
                m_busy = 0; m_run = 0; exp_grp = 0; exp_cls_o = 0; exp_max_o = 0;
            end else begin
                if (cif4.fcn_start && !prev_start) begin
                    if (!m_busy) begin
                        m_busy = 1;
                        m_run  = 0;
                    end else begin
                        m_run++;
                    end
                    exp_grp = 0;
                    mon_launch++;
                    chk("cls_sel", cif4.cls_sel_o, m_run);
                end else begin
                    exp_grp = (exp_grp + int'(prev_valid)) % 256;
                end
                chk("fc1_next", cif4.fcn_fc1_next, prev_valid);
                chk("fc1_group", cif4.fc1_group_o, exp_grp);
                if (done4) begin
                    mon_done++;
                    ref_argmax(ridx, rmax);
                    chk("runs_at_done", m_run, NC - 1);
                    chk("class_o", class4, ridx);
                    chk("max_logit_o", max4, rmax);
`ifdef FCN_LOGIT_DUMP_EN
                    for (int i = 0; i < NC; i++) chk("logits_o", dump4[i], tab[i]);
`endif
                    exp_cls_o = ridx;
                    exp_max_o = rmax;
                    m_busy = 0;
                end else begin
                    chk("class_hold", class4, exp_cls_o);
                    chk("max_hold", max4, exp_max_o);
                end
                chk("busy_o", busy4, m_busy);
            end
            prev_valid = cif4.fcn_fc1_valid;
            prev_rst   = rst;
            prev_start = cif4.fcn_start;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start4();
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
    endtask

    task automatic wait_done4(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done4 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!done4) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic set_rand_tab();
        for (int i = 0; i < NC; i++) tab[i] = LW'($urandom_range(0, 255)) - LW'(128);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int l0, d0, k;
        cif1.fcn_done      = 1'b0;
        cif1.fcn_logit     = '0;
        cif1.fcn_fc1_valid = 1'b0;
        set_rand_tab();
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("init_busy", busy4, 0);
        chk("init_class1", class1, 0);

        // 1: mixed-sign logits
        tab[0] = 5; tab[1] = -3; tab[2] = 12; tab[3] = 7;
        l0 = mon_launch; d0 = mon_done;
        pulse_start4();
        wait_done4("t1");
        chk("t1_class", class4, 2);
        chk("t1_max", max4, 12);
        cyc(2);
        chk("t1_launches", mon_launch - l0, 4);
        chk("t1_dones", mon_done - d0, 1);

        // 2: all negative with a tie
        tab[0] = -8; tab[1] = -2; tab[2] = -2; tab[3] = -9;
        pulse_start4();
        wait_done4("t2");
        chk("t2_class", class4, 1);
        chk("t2_max", max4, -2);

        // 3: three FC1 groups per run
        pulses_cfg = 3;
        set_rand_tab();
        pulse_start4();
        k = 0;
        @(negedge clk);
        while (!cif4.fcn_done && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("t3_grp_at_done", cif4.fc1_group_o, 3);
        wait_done4("t3");
        pulses_cfg = -1;

        // 4: start held and reasserted while busy
        set_rand_tab();
        l0 = mon_launch; d0 = mon_done;
        @(posedge clk); #1 start4 = 1'b1;
        cyc(5);
        start4 = 1'b0;
        cyc(4);
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        wait_done4("t4");
        cyc(15);
        chk("t4_launches", mon_launch - l0, 4);
        chk("t4_dones", mon_done - d0, 1);
        tab[0] = -100; tab[1] = -50; tab[2] = -70; tab[3] = -60;
        pulse_start4();
        wait_done4("t4b");
        chk("t4b_class", class4, 1);
        chk("t4b_max", max4, -50);

        // 5: reset during class 2
        set_rand_tab();
        pulse_start4();
        k = 0;
        @(negedge clk);
        while (!(cif4.cls_sel_o == 2 && cif4.fcn_start) && k < 300) begin @(negedge clk); k++; end
        chk("t5_reached_cls2", cif4.cls_sel_o, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_start", cif4.fcn_start, 0);
        chk("t5_busy", busy4, 0);
        chk("t5_class", class4, 0);
        cyc(4);
        for (int r = 0; r < 3; r++) begin
            set_rand_tab();
            pulse_start4();
            wait_done4("t5_rerun");
        end

        // 6: single-class build, most negative logit
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        k = 0;
        while (!cif1.fcn_start && k < 20) begin cyc(1); k++; end
        chk("t6_fcn_start", cif1.fcn_start, 1);
        chk("t6_cls_sel", cif1.cls_sel_o, 0);
        cyc(2);
        cif1.fcn_done  = 1'b1;
        cif1.fcn_logit = 24'h800000;
        k = 0;
        while (cif1.fcn_start && k < 20) begin cyc(1); k++; end
        cyc(1);
        cif1.fcn_done = 1'b0;
        k = 0;
        @(negedge clk);
        while (!done1 && k < 20) begin @(negedge clk); k++; end
        chk("t6_done", done1, 1);
        chk("t6_class", class1, 0);
        chk("t6_max", max1, -8388608);
        chk("t6_busy", busy1, 0);
`ifdef FCN_LOGIT_DUMP_EN
        chk("t6_dump", dump1[0], -8388608);
`endif
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fcn_class_seq.md
Name: fcn_class_seq

Overview:
Sequencer and argmax stage directly downstream of the fully-connected core.
- Runs the FC core once per output class, using the start/done level handshake.
- Selects the FC2 weight row per class and auto-acknowledges FC1 group handshakes.
- Keeps a running signed maximum of the returned 24-bit logits and reports the winning class index.

Parameters:
NUM_CLASS, 10, number of output classes; each class is one FC core run. Legal range 1..256.
LOGIT_W, 24, FC core logit width (signed).
CLS_W, $clog2(NUM_CLASS) with a minimum of 1, class index width (derived).
GRP_W, 8, FC1 group counter width.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous active-high reset.
start_i  in  1  request a full classification; sampled in IDLE only.
busy_o  out  1  high from the cycle after start_i is accepted until done_o.
done_o  out  1  one-cycle pulse; class_o and max_logit_o are valid from this cycle.
class_o  out  CLS_W  winning class index; held until the next done_o.
max_logit_o  out  LOGIT_W  signed winning logit; held until the next done_o.
fcn_start  out  1  level start to the FC core.
fcn_done  in  1  FC core done level.
fcn_logit  in  LOGIT_W  signed FC core logit; valid while fcn_done=1.
fcn_fc1_valid  in  1  FC core FC1 group-complete pulse.
fcn_fc1_next  out  1  one-cycle acknowledge to the FC core.
cls_sel_o  out  CLS_W  class currently running; the FC2 weight memory uses it as its row select.
fc1_group_o  out  GRP_W  index of the FC1 group being computed; the FC1 weight memory uses it.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal max register 0.
- States: IDLE, RUN, CAPTURE, RELEASE, FINISH.
- IDLE:
  - start_i=1 -> cls_sel_o<=0, fc1_group_o<=0, fcn_start<=1, busy_o<=1, first flag<=1, go to RUN.
- RUN:
  - fcn_fc1_valid=1 -> next cycle fcn_fc1_next=1 for exactly one cycle and fc1_group_o<=fc1_group_o+1 (wraps mod 2^GRP_W).
  - fcn_done=1 -> go to CAPTURE.
  - If fcn_fc1_valid and fcn_done are high in the same cycle, the ack is still issued. The done moves the FSM to CAPTURE, and the ack pulse fires in the first CAPTURE cycle.
- CAPTURE, one cycle:
  - If first flag=1, or fcn_logit > max register (signed, strictly greater), then max<=fcn_logit and best index<=cls_sel_o.
  - Ties keep the lower index.
  - first<=0; fcn_start<=0; go to RELEASE.
- RELEASE:
  - Wait until fcn_done=0. This takes at least 2 cycles because the FC core drops done one cycle after it reaches IDLE.
  - Then, if cls_sel_o==NUM_CLASS-1 -> FINISH.
  - Otherwise cls_sel_o+=1, fc1_group_o<=0, fcn_start<=1, go to RUN.
- FINISH, one cycle:
  - class_o<=best index, max_logit_o<=max; both are registered and visible in the same cycle as done_o.
  - done_o=1, busy_o<=0, go to IDLE.
- Latency: sum over classes of the FC core run time, plus at least 4 cycles per class (CAPTURE + RELEASE + relaunch), plus 1 cycle (FINISH).
- start_i while busy is ignored; there is no queueing.
- NUM_CLASS=1: one run; FINISH reports class 0 and the logit unchanged.
- The comparison is fully signed. An all-negative logit set returns the least-negative logit; the first flag prevents a spurious 0 winner.
- rst mid-run:
  - Next cycle: IDLE, fcn_start=0, fcn_fc1_next=0, busy_o=0.
  - class_o and max_logit_o cleared.
  - The FC core is expected to share the same reset.
- A fcn_done that is already high on entry to RUN is treated as done; RELEASE is what normally guarantees it is low by then.

Optional Feature:
Macro FCN_LOGIT_DUMP_EN.
- Defined:
  - Adds output port logits_o [0:NUM_CLASS-1] of signed LOGIT_W bits.
  - In CAPTURE, logits_o[cls_sel_o]<=fcn_logit.
  - Array cleared on rst and on start_i acceptance.
  - Contents valid at done_o and held until the next start.
- Not defined: no port and no storage; behaviour is otherwise identical.

Decomposition:
- Shared package fcn_pkg:
  - state enum fcn_seq_state_e.
  - LOGIT_W default constant.
  - Signed-max helper function (returns 1 when a>b).
- One natural sub-module: fcn_argmax_reg.
  - Holds the first flag, max and best index.
  - Inputs: clear, valid, logit, idx.
  - Outputs: max, idx.
- The FSM and counters stay in the top module.

Test Plan:
1. NUM_CLASS=4, model core returns logits {5, -3, 12, 7} -> done_o once; class_o=2, max_logit_o=12; fcn_start toggled 4 times.
2. Logits {-8, -2, -2, -9} -> class_o=1, max_logit_o=-2 (all-negative case and tie keeps the lower index).
3. Core pulses fcn_fc1_valid 3 times per run -> fcn_fc1_next one cycle after each pulse; fc1_group_o steps 0,1,2,3 and resets to 0 at each class launch; cls_sel_o matches the class run.
4. start_i held high through a run and reasserted during busy -> exactly one classification; a new start after done_o starts a fresh run with the first flag set.
5. rst asserted during class 2 of 4 -> next cycle fcn_start=0, busy_o=0, class_o=0; a following start_i gives a correct full result.
6. NUM_CLASS=1 with logit 0x800000 (most negative) -> class_o=0, max_logit_o=-8388608. With FCN_LOGIT_DUMP_EN defined, logits_o[0] matches.
